// File: rtl/key_pkg.sv
// Shared button index map and auto-repeat FSM encoding
// for the key input controller.
package key_pkg;

    localparam int N_BTN = 9;
    localparam int N_MOVE = 4;

    localparam int BTN_LEFT = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_UP = 2;
    localparam int BTN_DOWN = 3;
    localparam int BTN_ROTATE = 4;
    localparam int BTN_PLACE = 5;
    localparam int BTN_SEL1 = 6;
    localparam int BTN_SEL2 = 7;
    localparam int BTN_SEL3 = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } rpt_state_t;

endpackage

// File: rtl/debounce_cell.sv
// One button: 2-flop synchronizer, stable-count debouncer
// and a registered 0->1 edge flag.
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0] sync;
    logic [CW-1:0] cnt;
    logic hit;

    // The counter never goes past DEBOUNCE_CYCLES-1, so it cannot wrap.
    assign hit = (sync[1] != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync <= '0;
            cnt <= '0;
            level <= 1'b0;
            rise <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            rise <= hit & ~level;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (hit) begin
                cnt <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/key_input_ctrl.sv
// Debounced button front end producing single-cycle game commands.
// Define KEY_AUTO_REPEAT_EN to auto-repeat the four move buttons.
module key_input_ctrl
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY = 15000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic clk,
    input  logic resetn,
    input  logic [8:0] btn_raw,
    input  logic game_over,
    output logic move_left,
    output logic move_right,
    output logic move_up,
    output logic move_down,
    output logic rotate_block,
    output logic place_block,
    output logic sel1,
    output logic sel2,
    output logic sel3,
    output logic [8:0] btn_level
);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("key_input_ctrl: timing parameters must be >= 1");
    end

    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] cand;
    logic [N_BTN-1:0] cmd;
    logic [N_BTN-1:0] cmd_q;

    for (genvar i = 0; i < N_BTN; i++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clk(clk),
            .resetn(resetn),
            .raw(btn_raw[i]),
            .level(btn_level[i]),
            .rise(rise[i])
        );
    end

`ifdef KEY_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = (RMAX > 1) ? $clog2(RMAX) : 1;

    logic [N_MOVE-1:0] rpt;

    for (genvar i = 0; i < N_MOVE; i++) begin : g_rpt
        rpt_state_t st, st_nx;
        logic [RW-1:0] cnt, cnt_nx;
        logic fire;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                st <= ST_IDLE;
                cnt <= '0;
            end else begin
                st <= st_nx;
                cnt <= cnt_nx;
            end
        end

        // Holding through game over never arms: only a fresh rise leaves IDLE.
        always_comb begin
            st_nx = st;
            cnt_nx = cnt;
            fire = 1'b0;
            if (!btn_level[i] || game_over) begin
                st_nx = ST_IDLE;
                cnt_nx = '0;
            end else begin
                unique case (st)
                    ST_IDLE: begin
                        if (rise[i]) begin
                            st_nx = ST_DELAY;
                            cnt_nx = '0;
                        end
                    end
                    ST_DELAY: begin
                        if (cnt == RW'(REPEAT_DELAY - 1)) begin
                            fire = 1'b1;
                            st_nx = ST_REPEAT;
                            cnt_nx = '0;
                        end else begin
                            cnt_nx = cnt + RW'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (cnt == RW'(REPEAT_PERIOD - 1)) begin
                            fire = 1'b1;
                            cnt_nx = '0;
                        end else begin
                            cnt_nx = cnt + RW'(1);
                        end
                    end
                    default: begin
                        st_nx = ST_IDLE;
                        cnt_nx = '0;
                    end
                endcase
            end
        end

        assign rpt[i] = fire;
    end

    assign cand = rise | {{(N_BTN - N_MOVE){1'b0}}, rpt};
`else
    assign cand = rise;
`endif

    always_comb begin
        cmd = '0;
        if (!game_over) begin
            cmd[BTN_LEFT] = cand[BTN_LEFT] & ~cand[BTN_RIGHT];
            cmd[BTN_RIGHT] = cand[BTN_RIGHT] & ~cand[BTN_LEFT];
            cmd[BTN_UP] = cand[BTN_UP] & ~cand[BTN_DOWN];
            cmd[BTN_DOWN] = cand[BTN_DOWN] & ~cand[BTN_UP];
            cmd[BTN_ROTATE] = cand[BTN_ROTATE];
            cmd[BTN_PLACE] = cand[BTN_PLACE];
            cmd[BTN_SEL1] = cand[BTN_SEL1];
            cmd[BTN_SEL2] = cand[BTN_SEL2] & ~cand[BTN_SEL1];
            cmd[BTN_SEL3] = cand[BTN_SEL3] & ~cand[BTN_SEL1] & ~cand[BTN_SEL2];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cmd_q <= '0;
        end else begin
            cmd_q <= cmd;
        end
    end

    // Gate the registered pulse so game over silences it in its first cycle.
    assign move_left = cmd_q[BTN_LEFT] & ~game_over;
    assign move_right = cmd_q[BTN_RIGHT] & ~game_over;
    assign move_up = cmd_q[BTN_UP] & ~game_over;
    assign move_down = cmd_q[BTN_DOWN] & ~game_over;
    assign rotate_block = cmd_q[BTN_ROTATE] & ~game_over;
    assign place_block = cmd_q[BTN_PLACE] & ~game_over;
    assign sel1 = cmd_q[BTN_SEL1] & ~game_over;
    assign sel2 = cmd_q[BTN_SEL2] & ~game_over;
    assign sel3 = cmd_q[BTN_SEL3] & ~game_over;

endmodule

// File: tb/tb_key_input_ctrl.sv
// Directed bench for key_input_ctrl with short timing parameters;
// expectations follow KEY_AUTO_REPEAT_EN when it is defined.
module tb_key_input_ctrl;

    logic clk = 1'b0;
    logic resetn;
    logic [8:0] btn_raw;
    logic game_over;
    logic move_left, move_right, move_up, move_down;
    logic rotate_block, place_block, sel1, sel2, sel3;
    logic [8:0] btn_level;
    logic [8:0] cmd;

    int checks = 0;
    int errors = 0;
    logic [63:0] hist [9];

    always #5 clk = ~clk;

    assign cmd = {sel3, sel2, sel1, place_block, rotate_block,
                  move_down, move_up, move_right, move_left};

    key_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(5)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .btn_raw(btn_raw),
        .game_over(game_over),
        .move_left(move_left),
        .move_right(move_right),
        .move_up(move_up),
        .move_down(move_down),
        .rotate_block(rotate_block),
        .place_block(place_block),
        .sel1(sel1),
        .sel2(sel2),
        .sel3(sel3),
        .btn_level(btn_level)
    );

    // Record every command output for n falling edges; hist[b][c] is cycle c.
    task automatic watch(input int n);
        for (int b = 0; b < 9; b++) hist[b] = '0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            for (int b = 0; b < 9; b++) hist[b][c] = cmd[b];
        end
    endtask

    task automatic settle();
        btn_raw = '0;
        game_over = 1'b0;
        watch(14);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        btn_raw = '0;
        game_over = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (cmd !== 9'h000 || btn_level !== 9'h000) begin
            errors++;
            $display("FAIL reset_state cmd=%h level=%h want 000/000", cmd, btn_level);
        end
        resetn = 1'b1;
        watch(10);
        checks++;
        if ((hist[0] | hist[4] | hist[5] | hist[6]) !== 64'd0 || btn_level !== 9'h000) begin
            errors++;
            $display("FAIL reset_idle pulses seen or level=%h want 000", btn_level);
        end
    endtask

    task automatic test_place();
        logic [63:0] e;
        logic [63:0] others;
        e = 64'd1 << 7;
        btn_raw[5] = 1'b1;
        watch(20);
        checks++;
        if (hist[5] !== e) begin
            errors++;
            $display("FAIL place_pulse got %h want %h", hist[5], e);
        end
        others = '0;
        for (int b = 0; b < 9; b++) if (b != 5) others |= hist[b];
        checks++;
        if (others !== 64'd0) begin
            errors++;
            $display("FAIL place_others got %h want 0", others);
        end
        checks++;
        if (btn_level !== 9'h020) begin
            errors++;
            $display("FAIL place_level got %h want 020", btn_level);
        end
        btn_raw[5] = 1'b0;
        watch(12);
        checks++;
        if (hist[5] !== 64'd0 || btn_level !== 9'h000) begin
            errors++;
            $display("FAIL place_release pulses=%h level=%h want 0/000", hist[5], btn_level);
        end
    endtask

    task automatic test_bounce();
        logic seen_pulse;
        logic seen_level;
        seen_pulse = 1'b0;
        seen_level = 1'b0;
        for (int c = 0; c < 40; c++) begin
            btn_raw[0] = ((c / 2) % 2) == 0;
            @(negedge clk);
            seen_pulse |= move_left;
            seen_level |= btn_level[0];
        end
        checks++;
        if (seen_pulse !== 1'b0 || seen_level !== 1'b0) begin
            errors++;
            $display("FAIL bounce pulse=%b level=%b want 0/0", seen_pulse, seen_level);
        end
        settle();
    endtask

    task automatic test_repeat();
        logic [63:0] obs;
        logic [63:0] e;
        logic up_seen;
        obs = '0;
        up_seen = 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
        e = (64'd1 << 7) | (64'd1 << 17) | (64'd1 << 22) | (64'd1 << 27)
          | (64'd1 << 32) | (64'd1 << 37) | (64'd1 << 42);
`else
        e = 64'd1 << 7;
`endif
        btn_raw[3] = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            obs[c] = move_down;
            up_seen |= move_up;
            if (c == 40) btn_raw[3] = 1'b0;
        end
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL repeat_down got %h want %h", obs, e);
        end
        checks++;
        if (up_seen !== 1'b0 || btn_level !== 9'h000) begin
            errors++;
            $display("FAIL repeat_after up=%b level=%h want 0/000", up_seen, btn_level);
        end
        settle();
    endtask

    task automatic test_conflict();
        logic [63:0] e;
        e = 64'd1 << 7;
        btn_raw = 9'b000000011;
        watch(14);
        checks++;
        if ((hist[0] | hist[1]) !== 64'd0 || btn_level[1:0] !== 2'b11) begin
            errors++;
            $display("FAIL lr_conflict pulses=%h level=%b want 0/11",
                     hist[0] | hist[1], btn_level[1:0]);
        end
        settle();
        btn_raw = 9'b000001100;
        watch(14);
        checks++;
        if ((hist[2] | hist[3]) !== 64'd0) begin
            errors++;
            $display("FAIL ud_conflict pulses=%h want 0", hist[2] | hist[3]);
        end
        settle();
        btn_raw = 9'b101000000;
        watch(14);
        checks++;
        if (hist[6] !== e || (hist[7] | hist[8]) !== 64'd0) begin
            errors++;
            $display("FAIL sel_priority sel1=%h sel23=%h want %h/0",
                     hist[6], hist[7] | hist[8], e);
        end
        settle();
        btn_raw = 9'b000000001;
        watch(14);
        checks++;
        if (hist[0] !== e || hist[1] !== 64'd0) begin
            errors++;
            $display("FAIL left_alone left=%h right=%h want %h/0", hist[0], hist[1], e);
        end
        settle();
    endtask

    task automatic test_game_over();
        game_over = 1'b1;
        btn_raw = 9'b000010001;
        watch(14);
        checks++;
        if ((hist[0] | hist[4]) !== 64'd0) begin
            errors++;
            $display("FAIL go_masked pulses=%h want 0", hist[0] | hist[4]);
        end
        checks++;
        if (btn_level !== 9'h011) begin
            errors++;
            $display("FAIL go_level got %h want 011", btn_level);
        end
        game_over = 1'b0;
        watch(30);
        checks++;
        if ((hist[0] | hist[4]) !== 64'd0) begin
            errors++;
            $display("FAIL go_release pulses=%h want 0", hist[0] | hist[4]);
        end
        settle();
    endtask

    task automatic test_reset_mid();
        logic [63:0] e;
        e = 64'd1 << 7;
        btn_raw[2] = 1'b1;
        watch(3);
        checks++;
        if (hist[2] !== 64'd0) begin
            errors++;
            $display("FAIL mid_early got %h want 0", hist[2]);
        end
        resetn = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd !== 9'h000 || btn_level !== 9'h000) begin
            errors++;
            $display("FAIL mid_in_reset cmd=%h level=%h want 000/000", cmd, btn_level);
        end
        resetn = 1'b1;
        watch(14);
        checks++;
        if (hist[2] !== e) begin
            errors++;
            $display("FAIL mid_after got %h want %h", hist[2], e);
        end
        settle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_place();
        test_bounce();
        test_repeat();
        test_conflict();
        test_game_over();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_input_ctrl.md
KEY_INPUT_CTRL -- requirements
Module: key_input_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles before a debounced level changes.
REQ-002 SHALL have parameter REPEAT_DELAY, default 15000000, hold cycles from the first move pulse to the first auto-repeat pulse.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 5000000, cycles between subsequent auto-repeat pulses.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic SHALL be synchronous to its rising edge.
REQ-005 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port btn_raw, input, 9, asynchronous active-high buttons with index order: 0 left, 1 right, 2 up, 3 down, 4 rotate, 5 place, 6 sel1, 7 sel2, 8 sel3.
REQ-007 SHALL have port game_over, input, 1, the game-over flag from the game-logic stage.
REQ-008 SHALL have ports move_left, move_right, move_up, move_down, rotate_block, place_block, sel1, sel2, sel3, each output, 1, a single-cycle command pulse to the game-logic stage.
REQ-009 SHALL have port btn_level, output, 9, the debounced levels in btn_raw order, for debug LEDs.

Function
REQ-010 SHALL pass each btn_raw bit through a 2-flop synchronizer before any other logic.
REQ-011 SHALL keep one debounce counter per bit; it SHALL clear whenever the synchronized input equals btn_level, and otherwise increment.
REQ-012 SHALL toggle btn_level and clear the counter in the cycle the counter reaches DEBOUNCE_CYCLES-1.
REQ-013 SHALL assert a command output for exactly one cycle, in the cycle after its btn_level rises 0->1.
REQ-014 SHALL produce no pulse on a 1->0 debounced transition.
REQ-015 SHALL suppress move_left and move_right in any cycle where both would pulse; it SHALL likewise suppress move_up and move_down in any cycle where both would pulse.
REQ-016 SHALL, when more than one of sel1..sel3 would pulse in a cycle, emit only the lowest index (sel1 > sel2 > sel3).
REQ-017 SHALL force every command output to 0 while game_over=1; btn_level SHALL keep tracking the inputs.
REQ-018 SHALL restart hold tracking on game_over 1->0, so no pulse is emitted for a button already held at that point.
REQ-019 SHALL not auto-repeat rotate_block, place_block or sel1..sel3.
REQ-020 SHALL size each counter to $clog2 of the largest value it must reach, and no counter SHALL wrap.

Reset
REQ-021 SHALL, while resetn=0, clear the synchronizers, btn_level, all counters, auto-repeat state and all command outputs to 0.
REQ-022 SHALL, after resetn deasserts, require a full debounce interval before any pulse, even for a button held through reset.
REQ-023 SHALL abort an in-progress debounce or repeat interval on reset assertion, with no pulse emitted.

Configuration
REQ-024 SHALL, when macro KEY_AUTO_REPEAT_EN is defined, run one 3-state FSM per move button (IDLE, DELAY, REPEAT):
- IDLE->DELAY on the initial pulse;
- DELAY->REPEAT after REPEAT_DELAY cycles held, emitting a pulse;
- in REPEAT, a pulse every REPEAT_PERIOD cycles;
- any state->IDLE when btn_level falls.
REQ-025 SHALL, when KEY_AUTO_REPEAT_EN is undefined, omit the repeat FSMs and counters entirely, so one press yields one pulse.

Structure
REQ-026 SHALL take the button index constants and the FSM state encoding from shared package key_pkg.
REQ-027 SHALL implement the synchronizer, debounce counter and rising-edge pulse as sub-module debounce_cell, instantiated 9 times.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
REQ-028 SHALL cover: btn_raw[5] high for 20 cycles -> place_block high exactly one cycle, 2+4+1 cycles after the edge (the 2-cycle synchronizer, 4-cycle debounce and 1-cycle pulse stage); btn_level[5] high.
REQ-029 SHALL cover: btn_raw[0] toggling every 2 cycles for 40 cycles -> no move_left pulse, btn_level[0] stays 0.
REQ-030 SHALL cover: with KEY_AUTO_REPEAT_EN defined, btn_raw[3] held 40 cycles -> move_down pulses at the initial cycle t0, then t0+10, t0+15, t0+20 and onward until release; with it undefined -> one pulse only.
REQ-031 SHALL cover: btn_raw[0] and btn_raw[1] rising in the same cycle -> no move pulse; btn_raw[6] and btn_raw[8] together -> sel1 only.
REQ-032 SHALL cover: game_over=1 while btn_raw[4] rises -> rotate_block stays 0; game_over drops while the button is still held -> still no pulse.
REQ-033 SHALL cover: resetn pulsed low mid-debounce of btn_raw[2] with the button held -> no move_up pulse until 2+4+1 cycles after resetn rises.
